// File: rtl/fb_rect_fill_if.sv
// Command and pixel-write bundle between a drawing client, the rectangle fill
// engine and the framebuffer write port.
interface fb_rect_fill_if;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [9:0] CMD_X0;
   logic [9:0] CMD_X1;
   logic [9:0] CMD_Y0;
   logic [9:0] CMD_Y1;
   logic [7:0] CMD_COLOR;
   logic       WR_STALL;
   logic [9:0] PIX_HORIZONTAL;
   logic [9:0] PIX_VERTICAL;
   logic [7:0] PIX_COLOR;
   logic       PIX_WE;
   logic       BUSY;
   logic       DONE;

   modport master (
      output CMD_VALID, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1, CMD_COLOR, WR_STALL,
      input  CMD_READY, PIX_HORIZONTAL, PIX_VERTICAL, PIX_COLOR, PIX_WE, BUSY, DONE
   );

   modport slave (
      input  CMD_VALID, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1, CMD_COLOR, WR_STALL,
      output CMD_READY, PIX_HORIZONTAL, PIX_VERTICAL, PIX_COLOR, PIX_WE, BUSY, DONE
   );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: one clipped axis-aligned fill per command, one pixel
// write per unstalled cycle in raster order.
module fb_rect_fill #(
   parameter int unsigned HSIZE = 800,
   parameter int unsigned VSIZE = 600
) (
   input  logic           PIXEL_CLK,
   input  logic           RESET_N,
   fb_rect_fill_if.slave  fb
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

   localparam logic [9:0] X_LIM = 10'(HSIZE - 1);
   localparam logic [9:0] Y_LIM = 10'(VSIZE - 1);

   state_t     state_q, state_d;
   logic [9:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [7:0] color_q, color_d;
   logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
   logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [7:0] pix_c_q, pix_c_d;

   logic [9:0] x_lo, x_hi, y_lo, y_hi;
   logic       empty;
   logic       pix_we;

   always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         pix_x_q <= '0;
         pix_y_q <= '0;
         pix_c_q <= '0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         color_q <= color_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymax_q  <= ymax_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         pix_c_q <= pix_c_d;
      end
   end

   // Corner ordering and clipping of the captured command.
   always_comb begin
      x_lo  = (x0_q < x1_q) ? x0_q : x1_q;
      x_hi  = (x0_q < x1_q) ? x1_q : x0_q;
      y_lo  = (y0_q < y1_q) ? y0_q : y1_q;
      y_hi  = (y0_q < y1_q) ? y1_q : y0_q;
      empty = (x_lo > X_LIM) || (y_lo > Y_LIM);
   end

   assign pix_we = (state_q == S_FILL) && !fb.WR_STALL;

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      color_d = color_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymax_d  = ymax_q;
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      pix_c_d = pix_c_q;
      unique case (state_q)
         S_IDLE: begin
            if (fb.CMD_VALID) begin
               x0_d    = fb.CMD_X0;
               x1_d    = fb.CMD_X1;
               y0_d    = fb.CMD_Y0;
               y1_d    = fb.CMD_Y1;
               color_d = fb.CMD_COLOR;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            xmin_d  = x_lo;
            xmax_d  = (x_hi > X_LIM) ? X_LIM : x_hi;
            ymax_d  = (y_hi > Y_LIM) ? Y_LIM : y_hi;
            pix_x_d = x_lo;
            pix_y_d = y_lo;
            pix_c_d = color_q;
            state_d = empty ? S_DONE : S_FILL;
         end
         S_FILL: begin
            // The final write leaves the counters at the last pixel so they never pass xmax/ymax.
            if (pix_we) begin
               if (pix_x_q == xmax_q) begin
                  if (pix_y_q == ymax_q) begin
                     state_d = S_DONE;
                  end else begin
                     pix_x_d = xmin_q;
                     pix_y_d = pix_y_q + 10'd1;
                  end
               end else begin
                  pix_x_d = pix_x_q + 10'd1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign fb.CMD_READY      = (state_q == S_IDLE);
   assign fb.BUSY           = (state_q != S_IDLE);
   assign fb.DONE           = (state_q == S_DONE);
   assign fb.PIX_WE         = pix_we;
   assign fb.PIX_HORIZONTAL = pix_x_q;
   assign fb.PIX_VERTICAL   = pix_y_q;
   assign fb.PIX_COLOR      = pix_c_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: write sequences, clipping, empty fill,
// write stalls and reset abort.
module tb_fb_rect_fill;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fb_rect_fill_if bus ();

   fb_rect_fill #(.HSIZE(800), .VSIZE(600)) dut (
      .PIXEL_CLK (clk),
      .RESET_N   (rst_n),
      .fb        (bus.slave)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   wx[$];
   int   wy[$];
   int   wc[$];
   int   wt[$];
   int   done_cnt  = 0;
   int   done_cyc  = 0;
   int   bad_stall = 0;
   int   bad_range = 0;
   logic stall_en  = 1'b0;

   always @(negedge clk) begin
      if (bus.PIX_WE === 1'b1) begin
         wx.push_back(int'(bus.PIX_HORIZONTAL));
         wy.push_back(int'(bus.PIX_VERTICAL));
         wc.push_back(int'(bus.PIX_COLOR));
         wt.push_back(cyc);
         if (bus.WR_STALL !== 1'b0) bad_stall++;
         if (bus.PIX_HORIZONTAL > 10'd799 || bus.PIX_VERTICAL > 10'd599) bad_range++;
      end
      if (bus.DONE === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   always @(posedge clk) begin
      #1;
      if (stall_en) bus.WR_STALL = ~bus.WR_STALL;
      else          bus.WR_STALL = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [9:0] x0, input logic [9:0] x1,
                        input logic [9:0] y0, input logic [9:0] y1,
                        input logic [7:0] col, output int n);
      @(negedge clk); #1;
      chk("ready_before_cmd", 32'(bus.CMD_READY), 1);
      wx.delete(); wy.delete(); wc.delete(); wt.delete();
      done_cnt = 0;
      bus.CMD_X0 = x0; bus.CMD_X1 = x1; bus.CMD_Y0 = y0; bus.CMD_Y1 = y1;
      bus.CMD_COLOR = col;
      bus.CMD_VALID = 1'b1;
      n = cyc;
      @(posedge clk); #1;
      bus.CMD_VALID = 1'b0;
      bus.CMD_X0 = 10'd0; bus.CMD_X1 = 10'd1023;
      bus.CMD_Y0 = 10'd0; bus.CMD_Y1 = 10'd1023;
      bus.CMD_COLOR = ~col;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      chk("done_within_budget", 32'(done_cnt > 0), 1);
   endtask

   // Expected writes: raster over the given clipped box; timed = no stalls.
   task automatic check_rect(input string tag, input int n,
                             input int xlo, input int xhi, input int ylo, input int yhi,
                             input int col, input bit timed, input bit is_empty);
      int k = 0;
      int cnt;
      cnt = is_empty ? 0 : (xhi - xlo + 1) * (yhi - ylo + 1);
      wait_done(cnt * 3 + 20);
      chk({tag, "_count"}, 32'(wx.size()), 32'(cnt));
      if (!is_empty && wx.size() == cnt) begin
         for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
               chk({tag, "_x"}, 32'(wx[k]), 32'(x));
               chk({tag, "_y"}, 32'(wy[k]), 32'(y));
               chk({tag, "_color"}, 32'(wc[k]), 32'(col));
               if (timed) chk({tag, "_wr_cycle"}, 32'(wt[k]), 32'(n + 2 + k));
               k++;
            end
         end
      end
      if (timed || wt.size() == 0) chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(n + 2 + cnt));
      else chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(wt[wt.size()-1] + 1));
      chk({tag, "_ready_in_done"}, 32'(bus.CMD_READY), 0);
      @(negedge clk); #1;
      chk({tag, "_ready_after"}, 32'(bus.CMD_READY), 1);
      chk({tag, "_busy_after"}, 32'(bus.BUSY), 0);
      chk({tag, "_done_once"}, 32'(done_cnt), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_we"},    32'(bus.PIX_WE), 0);
      chk({tag, "_busy"},  32'(bus.BUSY), 0);
      chk({tag, "_done"},  32'(bus.DONE), 0);
      chk({tag, "_ready"}, 32'(bus.CMD_READY), 1);
      chk({tag, "_x"},     32'(bus.PIX_HORIZONTAL), 0);
      chk({tag, "_y"},     32'(bus.PIX_VERTICAL), 0);
      chk({tag, "_color"}, 32'(bus.PIX_COLOR), 0);
   endtask

   initial begin
      int n;
      int k;
      rst_n = 1'b0;
      bus.CMD_VALID = 1'b0;
      bus.CMD_X0 = '0; bus.CMD_X1 = '0; bus.CMD_Y0 = '0; bus.CMD_Y1 = '0;
      bus.CMD_COLOR = '0;
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;

      issue(10'd10, 10'd11, 10'd20, 10'd21, 8'h3C, n);
      check_rect("t1", n, 10, 11, 20, 21, 8'h3C, 1'b1, 1'b0);

      issue(10'd11, 10'd10, 10'd21, 10'd20, 8'h3C, n);
      check_rect("t2", n, 10, 11, 20, 21, 8'h3C, 1'b1, 1'b0);

      issue(10'd798, 10'd900, 10'd598, 10'd700, 8'hA5, n);
      check_rect("t3", n, 798, 799, 598, 599, 8'hA5, 1'b1, 1'b0);

      issue(10'd850, 10'd900, 10'd10, 10'd20, 8'h11, n);
      check_rect("t4", n, 0, 0, 0, 0, 8'h11, 1'b1, 1'b1);

      stall_en = 1'b1;
      issue(10'd10, 10'd11, 10'd20, 10'd21, 8'h3C, n);
      check_rect("t5", n, 10, 11, 20, 21, 8'h3C, 1'b0, 1'b0);
      stall_en = 1'b0;

      issue(10'd0, 10'd799, 10'd0, 10'd599, 8'h55, n);
      k = 0;
      while (wx.size() < 1000 && k < 2000) begin
         @(negedge clk); #1;
         k++;
      end
      chk("t6_writes_before_reset", 32'(wx.size()), 1000);
      if (wx.size() >= 1000) begin
         chk("t6_write1000_x", 32'(wx[999]), 199);
         chk("t6_write1000_y", 32'(wy[999]), 1);
      end
      rst_n = 1'b0;
      #1;
      check_idle_outputs("t6_in_reset");
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("t6_no_more_writes", 32'(wx.size()), 1000);
      chk("t6_no_done", 32'(done_cnt), 0);
      chk("t6_ready_after_release", 32'(bus.CMD_READY), 1);

      issue(10'd10, 10'd11, 10'd20, 10'd21, 8'h3C, n);
      check_rect("t6_next", n, 10, 11, 20, 21, 8'h3C, 1'b1, 1'b0);

      chk("never_write_during_stall", 32'(bad_stall), 0);
      chk("never_write_outside_screen", 32'(bad_range), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
